tape_rx: RTL and testbench

- Cassette input decoder for the Aquarius core: recovers bytes from the tape mark/space square-wave signal and writes them sequentially into RAM via a single-cycle write strobe.
- Exact inverse of the tape playback path:
  - Frame: 1 space start bit, D7..D0 MSB first (1 = mark, 0 = space), 1 mark stop bit.
  - Each bit is 2 full square-wave cycles.
  - Mark half-period = 1 playback tick (0.6 ms); space half-period = 2 ticks (1.2 ms).

---
 rtl/tape_rx_if.sv | 12 +
 rtl/tape_rx.sv | 208 ++++++++++++++++++++
 tb/tb_tape_rx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tape_rx_if.sv
// RAM write port and status outputs of the cassette decoder.
interface tape_rx_if;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [15:0] length;
    logic        busy;
    logic        err;

    modport master (output addr, data, we, length, busy, err);
    modport slave  (input  addr, data, we, length, busy, err);
endinterface

// File: rtl/tape_rx.sv
// Cassette input decoder: turns the mark/space square wave back into bytes
// and writes them to consecutive RAM addresses.
module tape_rx #(
    parameter int unsigned SHORT_MIN = 3,
    parameter int unsigned SHORT_MAX = 8,
    parameter int unsigned LONG_MAX  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       tape_in,
    input  logic [1:0] ctrl,
    tape_rx_if.master  bus
);
    localparam logic [4:0] S_MIN = 5'(SHORT_MIN);
    localparam logic [4:0] S_MAX = 5'(SHORT_MAX);
    localparam logic [4:0] L_MIN = 5'(SHORT_MAX + 1);
    localparam logic [4:0] L_MAX = 5'(LONG_MAX);

    typedef enum logic [1:0] {C_BAD, C_SHORT, C_LONG} cls_t;
    typedef enum logic [2:0] {B_IDLE, B_H1, B_H2, B_H3, B_H4} bstate_t;
    typedef enum logic [2:0] {M_OFF, M_HUNT, M_DATA, M_STOP, M_WRITE} mstate_t;

    logic       sync1, sync2, level;
    logic [4:0] cnt;
    logic       tog, rise;
    cls_t       half_cls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= tape_in;
            sync2 <= sync1;
            if (sample_en) level <= sync2;
            if (tog) cnt <= '0;
            else if (sample_en && cnt != '1) cnt <= cnt + 5'd1;
        end
    end

    assign tog  = sample_en && (sync2 != level);
    assign rise = tog && sync2;

    always_comb begin
        half_cls = C_BAD;
        if (cnt >= S_MIN && cnt <= S_MAX)      half_cls = C_SHORT;
        else if (cnt >= L_MIN && cnt <= L_MAX) half_cls = C_LONG;
    end

    // Bit decoder: four alternating halves of one class starting with a rise
    bstate_t    bst, bst_nx;
    cls_t       bcls, bcls_nx;
    logic       valid_nx, val_nx, abort_nx;
    logic       bit_valid, bit_val, bit_abort;
    logic [4:0] thr;

    assign thr = (bcls == C_SHORT) ? S_MIN : L_MIN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bst       <= B_IDLE;
            bcls      <= C_BAD;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
            bit_abort <= 1'b0;
        end else begin
            bst       <= bst_nx;
            bcls      <= bcls_nx;
            bit_valid <= valid_nx;
            bit_val   <= val_nx;
            bit_abort <= abort_nx;
        end
    end

    always_comb begin
        bst_nx   = bst;
        bcls_nx  = bcls;
        valid_nx = 1'b0;
        val_nx   = 1'b0;
        abort_nx = 1'b0;
        case (bst)
            B_IDLE: if (rise) bst_nx = B_H1;
            B_H1: begin
                if (tog) begin
                    if (half_cls == C_BAD) abort_nx = 1'b1;
                    else begin
                        bcls_nx = half_cls;
                        bst_nx  = B_H2;
                    end
                end else if (cnt > L_MAX) abort_nx = 1'b1;
            end
            B_H2, B_H3: begin
                if (tog) begin
                    if (half_cls != bcls) abort_nx = 1'b1;
                    else bst_nx = (bst == B_H2) ? B_H3 : B_H4;
                end else if (cnt > L_MAX) abort_nx = 1'b1;
            end
            B_H4: begin
                // Last half is accepted on length alone, so no trailing edge is needed
                if (tog) abort_nx = 1'b1;
                else if (cnt >= thr) begin
                    valid_nx = 1'b1;
                    val_nx   = (bcls == C_SHORT);
                    bst_nx   = B_IDLE;
                end
            end
            default: bst_nx = B_IDLE;
        endcase
        if (abort_nx) bst_nx = rise ? B_H1 : B_IDLE;
    end

    // Main framing FSM
    mstate_t     mst, mst_nx;
    logic        armed, arm, set_err, wr_go, shift_en;
    logic [2:0]  nbits;
    logic [7:0]  shreg;
    logic [15:0] addr_q, length_q;
    logic [7:0]  data_q;
    logic        we_q, err_q;

    assign armed = (ctrl == 2'd2);

    always_comb begin
        mst_nx   = mst;
        arm      = 1'b0;
        set_err  = 1'b0;
        wr_go    = 1'b0;
        shift_en = 1'b0;
        case (mst)
            M_OFF: if (armed) begin
                arm    = 1'b1;
                mst_nx = M_HUNT;
            end
            M_HUNT: if (bit_valid && !bit_val) mst_nx = M_DATA;
            M_DATA: begin
                if (bit_abort) begin
                    set_err = 1'b1;
                    mst_nx  = M_HUNT;
                end else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (nbits == 3'd7) mst_nx = M_STOP;
                end
            end
            M_STOP: begin
                if (bit_abort || (bit_valid && !bit_val)) begin
                    set_err = 1'b1;
                    mst_nx  = M_HUNT;
                end else if (bit_valid) begin
                    if (length_q == '1) begin
                        set_err = 1'b1;
                        mst_nx  = M_HUNT;
                    end else mst_nx = M_WRITE;
                end
            end
            M_WRITE: begin
                wr_go  = 1'b1;
                mst_nx = M_HUNT;
            end
            default: mst_nx = M_OFF;
        endcase
        // Disarm wins over sample events; a write already issued still completes
        if (!armed && mst != M_OFF) begin
            mst_nx   = M_OFF;
            set_err  = 1'b0;
            shift_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mst      <= M_OFF;
            nbits    <= '0;
            shreg    <= '0;
            addr_q   <= '0;
            length_q <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mst  <= mst_nx;
            we_q <= wr_go;
            if (wr_go) data_q <= shreg;
            if (mst != M_DATA) nbits <= '0;
            else if (shift_en) nbits <= nbits + 3'd1;
            if (shift_en) shreg <= {shreg[6:0], bit_val};
            if (we_q) begin
                length_q <= length_q + 16'd1;
                if (addr_q != '1) addr_q <= addr_q + 16'd1;
            end
            if (set_err) err_q <= 1'b1;
            if (arm) begin
                addr_q   <= '0;
                length_q <= '0;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.addr   = addr_q;
    assign bus.data   = data_q;
    assign bus.we     = we_q;
    assign bus.length = length_q;
    assign bus.busy   = (mst != M_OFF);
    assign bus.err    = err_q;
endmodule

// File: tb/tb_tape_rx.sv
// Directed-plus-random bench for tape_rx with a frame-level reference model.
module tb_tape_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b0;
    logic       tape_in = 1'b0;
    logic [1:0] ctrl = 2'd0;

    tape_rx_if bus();

    tape_rx #(.SHORT_MIN(3), .SHORT_MAX(8), .LONG_MAX(16)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .tape_in(tape_in), .ctrl(ctrl), .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: writes expected from whole frames, not from bit timing
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [15:0] exp_len = '0;
    logic        exp_err = 1'b0;
    int unsigned wide_we = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            obs_q.push_back({bus.addr, bus.data});
            if (prev_we) wide_we++;
        end
        prev_we = (bus.we === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input logic lvl, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tape_in = lvl;
            @(negedge clk);
            @(negedge clk);
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
        end
    endtask

    function automatic int unsigned half_len(input logic b, input logic jit);
        if (b) return jit ? $urandom_range(7, 4) : 6;
        return jit ? $urandom_range(15, 10) : 12;
    endfunction

    task automatic send_bit(input logic b, input logic jit);
        samp(1'b1, half_len(b, jit));
        samp(1'b0, half_len(b, jit));
        samp(1'b1, half_len(b, jit));
        samp(1'b0, half_len(b, jit));
    endtask

    task automatic frame(input logic [7:0] d, input logic jit, input logic stop_ok);
        logic [7:0] v;
        v = d;
        send_bit(1'b0, jit);
        for (int i = 7; i >= 0; i--) send_bit(v[i], jit);
        send_bit(stop_ok, jit);
        if (ctrl == 2'd2) begin
            if (!stop_ok) exp_err = 1'b1;
            else if (exp_len == 16'hFFFF) exp_err = 1'b1;
            else begin
                exp_q.push_back({exp_len, d});
                exp_len = exp_len + 16'd1;
            end
        end
    endtask

    task automatic rearm();
        ctrl = 2'd0;
        @(negedge clk);
        @(negedge clk);
        ctrl = 2'd2;
        @(negedge clk);
        exp_len = '0;
        exp_err = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic compare(input string tag);
        samp(1'b0, 4);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_length"}, 32'(bus.length), 32'(exp_len));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        // Reset state
        #1;
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_data", 32'(bus.data), 0);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_length", 32'(bus.length), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rearm();
        chk("arm_busy", 32'(bus.busy), 1);

        // Exact-timing single frame after a mark leader
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        frame(8'hA5, 1'b0, 1'b1);
        compare("a5");

        // Back-to-back frames
        rearm();
        frame(8'h00, 1'b0, 1'b1);
        frame(8'hFF, 1'b0, 1'b1);
        frame(8'h3C, 1'b0, 1'b1);
        compare("b2b");

        // Jittered timing, then random bytes
        rearm();
        frame(8'h00, 1'b1, 1'b1);
        frame(8'hFF, 1'b1, 1'b1);
        frame(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            frame(rb, 1'b1, 1'b1);
        end
        compare("jitter");

        // Bad stop bit, then recovery
        rearm();
        frame(8'h5A, 1'b0, 1'b0);
        compare("badstop");
        frame(8'h11, 1'b0, 1'b1);
        compare("after_badstop");

        // Glitch inside a data bit, silence, then recovery
        rearm();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        samp(1'b1, 3);
        samp(1'b0, 1);
        samp(1'b1, 2);
        samp(1'b0, 20);
        exp_err = 1'b1;
        compare("glitch");
        frame(8'h3C, 1'b1, 1'b1);
        compare("after_glitch");

        // Async reset in the middle of a byte
        rearm();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        frame(8'h77, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_addr", 32'(bus.addr), 0);
        chk("arst_data", 32'(bus.data), 0);
        chk("arst_length", 32'(bus.length), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_err", 32'(bus.err), 0);
        @(negedge clk);
        reset = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_len = '0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("rearm_busy", 32'(bus.busy), 1);

        // Disarm mid-byte: partial byte dropped, status held
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        ctrl = 2'd0;
        @(negedge clk);
        chk("drop_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        compare("dropped");
        chk("we_width", wide_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
